rob_alloc_ctrl: RTL and testbench

ROB_ALLOC_CTRL -- requirements
Module: rob_alloc_ctrl

---
 rtl/rob_alloc_ctrl.sv | 111 +++++++++++
 tb/tb_rob_alloc_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rob_alloc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rob_alloc_ctrl: ROB head/tail allocation, writeback steering and commit   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rob_alloc_ctrl #(
  parameter int ROB_DEPTH = 8,
  parameter int ROB_IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alloc_req,
  output logic                 alloc_ack,
  output logic [ROB_IDX_W-1:0] alloc_idx,
  output logic [ROB_DEPTH-1:0] line_write_en,
  input  logic                 wb_en,
  input  logic [ROB_IDX_W-1:0] wb_idx,
  output logic [ROB_DEPTH-1:0] line_update_en,
  input  logic [ROB_DEPTH-1:0] line_done,
  output logic                 commit_valid,
  output logic [ROB_IDX_W-1:0] commit_idx,
  input  logic                 commit_ack,
  output logic [ROB_IDX_W:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 wb_err
);

  localparam logic [ROB_IDX_W:0]   DEPTH_CNT = (ROB_IDX_W+1)'(ROB_DEPTH);
  localparam logic [ROB_IDX_W:0]   CNT_ONE   = (ROB_IDX_W+1)'(1);
  localparam logic [ROB_IDX_W-1:0] IDX_ONE   = ROB_IDX_W'(1);
  localparam logic [ROB_DEPTH-1:0] ONE_HOT0  = ROB_DEPTH'(1);

  logic [ROB_IDX_W-1:0] head_q, head_d;
  logic [ROB_IDX_W-1:0] tail_q, tail_d;
  logic [ROB_IDX_W:0]   count_q, count_d;
  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic                 wb_err_q, wb_err_d;

  logic wb_hit;
  logic wb_miss;
  logic commit_fire;

  always_comb begin
    full         = (count_q == DEPTH_CNT);
    empty        = (count_q == '0);
    // Full is taken from the registered count, so a same-cycle commit never frees a slot early.
    alloc_ack    = alloc_req & ~full & ~flush;
    wb_hit       = wb_en & valid_q[wb_idx] & ~flush;
    wb_miss      = wb_en & ~valid_q[wb_idx] & ~flush;
    commit_valid = ~empty & valid_q[head_q] & line_done[head_q] & ~flush;
    commit_fire  = commit_valid & commit_ack;

    line_write_en  = alloc_ack ? (ONE_HOT0 << tail_q) : '0;
    line_update_en = wb_hit    ? (ONE_HOT0 << wb_idx) : '0;
  end

  assign alloc_idx  = tail_q;
  assign commit_idx = head_q;
  assign count      = count_q;
  assign wb_err     = wb_err_q;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    valid_d  = valid_q;
    wb_err_d = wb_err_q | wb_miss;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      // Head and tail differ whenever both fire: commit needs non-empty, alloc needs non-full.
      if (commit_fire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + IDX_ONE;
      end
      if (alloc_ack) begin
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + IDX_ONE;
      end
      if (alloc_ack && !commit_fire) begin
        count_d = count_q + CNT_ONE;
      end else if (commit_fire && !alloc_ack) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      wb_err_q <= wb_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_alloc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rob_alloc_ctrl: directed scoreboard bench for rob_alloc_ctrl           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rob_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       alloc_req = 1'b0;
  logic       alloc_ack;
  logic [2:0] alloc_idx;
  logic [7:0] line_write_en;
  logic       wb_en = 1'b0;
  logic [2:0] wb_idx = 3'd0;
  logic [7:0] line_update_en;
  logic [7:0] line_done = 8'h00;
  logic       commit_valid;
  logic [2:0] commit_idx;
  logic       commit_ack = 1'b0;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       wb_err;

  typedef struct {
    string      nm;
    logic       ack;
    logic [2:0] aidx;
    logic [7:0] wen;
    logic [7:0] uen;
    logic       cv;
    logic [2:0] cidx;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] commit_q[$];
  int         checks = 0;
  int         failures = 0;

  rob_alloc_ctrl #(.ROB_DEPTH(8), .ROB_IDX_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_req(alloc_req), .alloc_ack(alloc_ack), .alloc_idx(alloc_idx),
    .line_write_en(line_write_en),
    .wb_en(wb_en), .wb_idx(wb_idx), .line_update_en(line_update_en),
    .line_done(line_done),
    .commit_valid(commit_valid), .commit_idx(commit_idx), .commit_ack(commit_ack),
    .count(count), .full(full), .empty(empty), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  // Monitor: one expected vector per driven cycle, plus retired-index ordering.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (alloc_ack !== e.ack || alloc_idx !== e.aidx || line_write_en !== e.wen ||
          line_update_en !== e.uen || commit_valid !== e.cv || commit_idx !== e.cidx ||
          count !== e.cnt || full !== e.full || empty !== e.empty || wb_err !== e.err) begin
        failures++;
        $display("FAIL %s: got ack=%b aidx=%0d wen=%h uen=%h cv=%b cidx=%0d cnt=%0d full=%b empty=%b err=%b; want ack=%b aidx=%0d wen=%h uen=%h cv=%b cidx=%0d cnt=%0d full=%b empty=%b err=%b",
                 e.nm, alloc_ack, alloc_idx, line_write_en, line_update_en, commit_valid,
                 commit_idx, count, full, empty, wb_err, e.ack, e.aidx, e.wen, e.uen, e.cv,
                 e.cidx, e.cnt, e.full, e.empty, e.err);
      end
    end
    if (!rst && commit_valid && commit_ack) begin
      checks++;
      if (commit_q.size() == 0) begin
        failures++;
        $display("FAIL commit_order: got unexpected retire idx=%0d, want none", commit_idx);
      end else begin
        logic [2:0] want;
        want = commit_q.pop_front();
        if (commit_idx !== want) begin
          failures++;
          $display("FAIL commit_order: got idx=%0d, want idx=%0d", commit_idx, want);
        end
      end
    end
  end

  task automatic step(input string nm,
                      input logic f, input logic ar, input logic we, input logic [2:0] wi,
                      input logic [7:0] ld, input logic ca,
                      input logic e_ack, input logic [2:0] e_aidx, input logic [7:0] e_wen,
                      input logic [7:0] e_uen, input logic e_cv, input logic [2:0] e_cidx,
                      input logic [3:0] e_cnt, input logic e_err);
    exp_t e;
    @(posedge clk);
    #1;
    flush = f; alloc_req = ar; wb_en = we; wb_idx = wi; line_done = ld; commit_ack = ca;
    e.nm = nm; e.ack = e_ack; e.aidx = e_aidx; e.wen = e_wen; e.uen = e_uen;
    e.cv = e_cv; e.cidx = e_cidx; e.cnt = e_cnt; e.err = e_err;
    e.full = (e_cnt == 4'd8);
    e.empty = (e_cnt == 4'd0);
    exp_q.push_back(e);
    if (ca && e_cv) commit_q.push_back(e_cidx);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; flush = 1'b0; alloc_req = 1'b0; wb_en = 1'b0; wb_idx = 3'd0;
    line_done = 8'h00; commit_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    step("rst_state", 0,0,0,3'd0,8'h00,0, 0,3'd0,8'h00,8'h00,0,3'd0,4'd0,0);

    // Fill to capacity, then one refused request.
    for (int i = 0; i < 8; i++)
      step($sformatf("fill%0d", i), 0,1,0,3'd0,8'h00,0,
           1,3'(i),8'(1 << i),8'h00,0,3'd0,4'(i),0);
    step("fill_refused", 0,1,0,3'd0,8'h00,0, 0,3'd0,8'h00,8'h00,0,3'd0,4'd8,0);

    // Commit and alloc together while full: only the commit happens.
    step("full_both",  0,1,0,3'd0,8'hFF,1, 0,3'd0,8'h00,8'h00,1,3'd0,4'd8,0);
    step("full_alloc", 0,1,0,3'd0,8'hFF,0, 1,3'd0,8'h01,8'h00,1,3'd1,4'd7,0);
    step("full_again", 0,0,0,3'd0,8'hFF,0, 0,3'd1,8'h00,8'h00,1,3'd1,4'd8,0);

    do_reset();
    step("rst_midop", 0,0,0,3'd0,8'h00,0, 0,3'd0,8'h00,8'h00,0,3'd0,4'd0,0);

    // Out-of-order completion; head waits for entry 0.
    step("ooo_a0", 0,1,0,3'd0,8'h00,0, 1,3'd0,8'h01,8'h00,0,3'd0,4'd0,0);
    step("ooo_a1", 0,1,0,3'd0,8'h00,0, 1,3'd1,8'h02,8'h00,0,3'd0,4'd1,0);
    step("ooo_a2", 0,1,0,3'd0,8'h00,0, 1,3'd2,8'h04,8'h00,0,3'd0,4'd2,0);
    step("ooo_wb2", 0,0,1,3'd2,8'h00,0, 0,3'd3,8'h00,8'h04,0,3'd0,4'd3,0);
    step("ooo_wb1", 0,0,1,3'd1,8'h04,0, 0,3'd3,8'h00,8'h02,0,3'd0,4'd3,0);
    step("ooo_wait", 0,0,0,3'd0,8'h06,0, 0,3'd3,8'h00,8'h00,0,3'd0,4'd3,0);
    step("ooo_cmt0", 0,0,1,3'd0,8'h07,1, 0,3'd3,8'h00,8'h01,1,3'd0,4'd3,0);
    step("ooo_cmt1", 0,0,0,3'd0,8'h07,1, 0,3'd3,8'h00,8'h00,1,3'd1,4'd2,0);
    step("ooo_cmt2", 0,0,0,3'd0,8'h07,1, 0,3'd3,8'h00,8'h00,1,3'd2,4'd1,0);
    step("ooo_empty", 0,0,0,3'd0,8'h00,0, 0,3'd3,8'h00,8'h00,0,3'd3,4'd0,0);

    // Writeback to an unallocated entry sets a sticky error.
    step("bad_wb",     0,0,1,3'd3,8'h00,0, 0,3'd3,8'h00,8'h00,0,3'd3,4'd0,0);
    step("err_set",    0,0,0,3'd0,8'h00,0, 0,3'd3,8'h00,8'h00,0,3'd3,4'd0,1);
    step("err_hold",   0,1,0,3'd0,8'h00,0, 1,3'd3,8'h08,8'h00,0,3'd3,4'd0,1);
    step("err_hold2",  0,0,0,3'd0,8'h00,0, 0,3'd4,8'h00,8'h00,0,3'd3,4'd1,1);

    do_reset();
    step("rst_clr_err", 0,0,0,3'd0,8'h00,0, 0,3'd0,8'h00,8'h00,0,3'd0,4'd0,0);

    // Pointer wrap.
    for (int i = 0; i < 6; i++)
      step($sformatf("wrap_a%0d", i), 0,1,0,3'd0,8'h00,0,
           1,3'(i),8'(1 << i),8'h00,0,3'd0,4'(i),0);
    for (int i = 0; i < 6; i++)
      step($sformatf("wrap_c%0d", i), 0,0,0,3'd0,8'h3F,1,
           0,3'd6,8'h00,8'h00,1,3'(i),4'(6 - i),0);
    for (int j = 0; j < 4; j++)
      step($sformatf("wrap_b%0d", j), 0,1,0,3'd0,8'h00,0,
           1,3'((6 + j) % 8),8'(1 << ((6 + j) % 8)),8'h00,0,3'd6,4'(j),0);
    step("wrap_idle", 0,0,0,3'd0,8'h00,0, 0,3'd2,8'h00,8'h00,0,3'd6,4'd4,0);

    // Flush with everything requested at once; error flag survives it.
    step("pre_flush",  0,1,1,3'd5,8'h00,0, 1,3'd2,8'h04,8'h00,0,3'd6,4'd4,0);
    step("flush",      1,1,1,3'd6,8'hFF,1, 0,3'd3,8'h00,8'h00,0,3'd6,4'd5,1);
    step("post_flush", 0,0,0,3'd0,8'h00,0, 0,3'd0,8'h00,8'h00,0,3'd0,4'd0,1);
    step("flush_alloc",0,1,0,3'd0,8'h00,0, 1,3'd0,8'h01,8'h00,0,3'd0,4'd0,1);
    step("flush_cnt",  0,0,0,3'd0,8'h00,0, 0,3'd1,8'h00,8'h00,0,3'd0,4'd1,1);

    do_reset();
    step("rst_final", 0,0,0,3'd0,8'h00,0, 0,3'd0,8'h00,8'h00,0,3'd0,4'd0,0);

    @(posedge clk);
    #1;
    alloc_req = 1'b0; wb_en = 1'b0; commit_ack = 1'b0; flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || commit_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d vectors and %0d retires pending, want 0 and 0",
               exp_q.size(), commit_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
